// File: rtl/ssemi_cic_interpolator.sv
// rtl/ssemi_cic_interpolator.sv - CIC interpolator: comb, zero-stuff by R, integrate, normalise, saturate
// Optional build macro: SSEMI_CIC_INTERP_ROUND_EN (round half up before the normalising shift)
module ssemi_cic_interpolator #(
  parameter int CIC_STAGES         = 4,
  parameter int DIFFERENTIAL_DELAY = 1,
  parameter int INTERP_FACTOR      = 32,
  parameter int INPUT_DATA_WIDTH   = 24,
  parameter int OUTPUT_DATA_WIDTH  = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_enable,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic signed [INPUT_DATA_WIDTH-1:0]  i_data,
  output logic signed [OUTPUT_DATA_WIDTH-1:0] o_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  input  logic                                i_clear_status,
  output logic                                o_underrun,
  output logic                                o_overflow,
  output logic                                o_busy,
  output logic [1:0]                          o_state
);

  localparam int N      = CIC_STAGES;
  localparam int M      = DIFFERENTIAL_DELAY;
  localparam int R      = INTERP_FACTOR;
  localparam int IW     = INPUT_DATA_WIDTH;
  localparam int OW     = OUTPUT_DATA_WIDTH;
  localparam int GROWTH = N * $clog2(R * M);
  localparam int AW     = IW + GROWTH;
  localparam int SHIFT  = GROWTH - $clog2(R) + IW - OW;
  localparam int PW     = $clog2(R);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_STARVED = 2'b10;

  localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

  logic signed [AW-1:0] r_dly   [0:N-1][0:M-1];
  logic signed [AW-1:0] r_integ [0:N-1];
  logic signed [AW-1:0] r_hold;
  logic                 r_hold_full;
  logic [PW-1:0]        r_phase;
  logic signed [OW-1:0] r_data;
  logic                 r_valid;
  logic [1:0]           r_state;
  logic                 r_underrun;
  logic                 r_overflow;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_consume;
  logic                 w_starve;
  logic signed [AW-1:0] w_integ_in;
  logic signed [AW-1:0] w_comb_in [0:N-1];
  logic signed [AW-1:0] w_comb_out;
  logic signed [AW:0]   w_tail;
  logic signed [AW:0]   w_biased;
  logic signed [AW:0]   w_shifted;
  logic                 w_hi;
  logic                 w_lo;
  logic                 w_clamp;
  logic signed [OW-1:0] w_sat_data;

  // Reset is folded in so the port reads not-ready during the reset cycle itself.
  assign w_ready    = i_enable && !r_hold_full && !i_rst;
  assign w_accept   = i_valid && w_ready;
  assign w_step     = i_enable && (!r_valid || i_ready) && ((r_phase != '0) || r_hold_full);
  assign w_consume  = w_step && (r_phase == '0);
  assign w_starve   = i_enable && (r_state == ST_RUN) && (r_phase == '0) && !r_hold_full;
  assign w_integ_in = w_consume ? r_hold : '0;

  always_comb begin : p_comb_chain
    logic signed [AW-1:0] v_acc;
    v_acc = {{(AW - IW){i_data[IW-1]}}, i_data};
    for (int k = 0; k < N; k++) begin
      w_comb_in[k] = v_acc;
      v_acc        = v_acc - r_dly[k][M-1];
    end
    w_comb_out = v_acc;
  end

  assign w_tail = {r_integ[N-1][AW-1], r_integ[N-1]};

`ifdef SSEMI_CIC_INTERP_ROUND_EN
  localparam int             RSH     = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW:0]    ROUND_K = (SHIFT > 0) ? ((AW + 1)'(1) << RSH) : '0;
  assign w_biased = w_tail + $signed(ROUND_K);
`else
  assign w_biased = w_tail;
`endif

  assign w_shifted  = w_biased >>> SHIFT;
  assign w_hi       = w_shifted > SAT_MAX;
  assign w_lo       = w_shifted < SAT_MIN;
  assign w_clamp    = w_hi || w_lo;
  assign w_sat_data = w_hi ? {1'b0, {(OW - 1){1'b1}}} :
                      w_lo ? {1'b1, {(OW - 1){1'b0}}} : w_shifted[OW-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      for (int k = 0; k < N; k++) begin
        r_integ[k] <= '0;
        for (int j = 0; j < M; j++) begin
          r_dly[k][j] <= '0;
        end
      end
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_phase     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_state     <= ST_IDLE;
    end else begin
      if (w_accept) begin
        r_hold      <= w_comb_out;
        r_hold_full <= 1'b1;
        for (int k = 0; k < N; k++) begin
          r_dly[k][0] <= w_comb_in[k];
          for (int j = 1; j < M; j++) begin
            r_dly[k][j] <= r_dly[k][j-1];
          end
        end
      end else if (w_consume) begin
        r_hold_full <= 1'b0;
      end

      // Nonblocking updates give each integrator its predecessor's pre-step value.
      if (w_step) begin
        r_integ[0] <= r_integ[0] + w_integ_in;
        for (int k = 1; k < N; k++) begin
          r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
        r_data  <= w_sat_data;
        r_valid <= 1'b1;
        r_phase <= r_phase + PW'(1);
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE:    if (r_hold_full) r_state <= ST_RUN;
        ST_RUN:     if (w_starve)    r_state <= ST_STARVED;
        ST_STARVED: if (r_hold_full) r_state <= ST_RUN;
        default:                     r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags survive the enable flush; only reset or an explicit clear drops them.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear_status) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_starve)          r_underrun <= 1'b1;
      if (w_step && w_clamp) r_overflow <= 1'b1;
    end
  end

  assign o_ready    = w_ready;
  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_underrun = r_underrun;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state == ST_RUN);
  assign o_state    = r_state;

endmodule

// File: tb/tb_ssemi_cic_interpolator.sv
// tb/tb_ssemi_cic_interpolator.sv - randomized bench against a convolution model of the CIC interpolator
module tb_ssemi_cic_interpolator;

  localparam int N      = 2;
  localparam int M      = 1;
  localparam int R      = 4;
  localparam int IW     = 24;
  localparam int OW     = 16;
  localparam int GROWTH = N * $clog2(R * M);
  localparam int SHIFT  = GROWTH - $clog2(R) + IW - OW;
  localparam int HLEN   = N * (R * M - 1) + 1;
  localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OW - 1));

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_enable;
  logic                 i_valid;
  logic                 o_ready;
  logic signed [IW-1:0] i_data;
  logic signed [OW-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 i_clear_status;
  logic                 o_underrun;
  logic                 o_overflow;
  logic                 o_busy;
  logic [1:0]           o_state;

  ssemi_cic_interpolator #(
    .CIC_STAGES(N), .DIFFERENTIAL_DELAY(M), .INTERP_FACTOR(R),
    .INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .i_clear_status(i_clear_status), .o_underrun(o_underrun),
    .o_overflow(o_overflow), .o_busy(o_busy), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint xs[$];
  longint h [0:HLEN-1];
  int     n_out = 0;
  bit     exp_ovf = 1'b0;
  bit     tbl_en = 1'b0;
  bit     stab_pending = 1'b0;
  longint stab_val;
  longint last_out = 0;
  longint exp_v;
  bit     exp_cl;
  int     rdy_mode = 0;
  int     imp_tbl [0:11] = '{0, 0, 64, 128, 192, 256, 192, 128, 64, 0, 0, 0};

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Impulse response of N cascaded length-R*M boxcars.
  task automatic build_h();
    longint t [0:HLEN-1];
    int len;
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    len  = 1;
    repeat (N) begin
      for (int i = 0; i < HLEN; i++) t[i] = 0;
      for (int a = 0; a < len; a++)
        for (int b = 0; b < R * M; b++)
          t[a + b] += h[a];
      h = t;
      len += R * M - 1;
    end
  endtask

  // Output j is the j-th step since flush; sample i enters at step i*R and shows up N steps later.
  function automatic longint model_out(input int j, output bit clamp);
    longint acc = 0;
    longint q;
    for (int i = 0; i < xs.size(); i++) begin
      int d = j - N - i * R;
      if (d >= 0 && d < HLEN) acc += xs[i] * h[d];
    end
`ifdef SSEMI_CIC_INTERP_ROUND_EN
    acc += longint'(1) << (SHIFT - 1);
`endif
    q = acc >>> SHIFT;
    clamp = 1'b0;
    if (q > OMAX) begin q = OMAX; clamp = 1'b1; end
    if (q < OMIN) begin q = OMIN; clamp = 1'b1; end
    return q;
  endfunction

  always @(negedge clk) begin
    if (i_enable && !i_rst) begin
      if (stab_pending) check("hold_stable", longint'(o_data), stab_val);
      stab_pending = 1'b0;
      if (i_valid && o_ready) xs.push_back(longint'(i_data));
      if (o_valid && i_ready) begin
        exp_v = model_out(n_out, exp_cl);
        if (exp_cl) exp_ovf = 1'b1;
        check("out", longint'(o_data), exp_v);
        if (tbl_en && n_out < 12) check("imp_tbl", longint'(o_data), imp_tbl[n_out]);
        check("ovf_track", o_overflow, exp_ovf);
        last_out = o_data;
        n_out++;
      end
      if (o_valid && !i_ready) begin
        stab_pending = 1'b1;
        stab_val     = o_data;
      end
    end
  end

  initial i_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    xs.delete();
    n_out        = 0;
    stab_pending = 1'b0;
  endtask

  task automatic do_flush(input bit do_checks);
    i_enable = 1'b0;
    tick(1);
    flush_model();
    if (do_checks) begin
      check("flush_valid", o_valid, 0);
      check("flush_ready", o_ready, 0);
      check("flush_state", o_state, 0);
      check("flush_data", longint'(o_data), 0);
    end
    i_enable = 1'b1;
  endtask

  task automatic send(input longint v);
    int waited = 0;
    i_valid = 1'b1;
    i_data  = IW'(v);
    while (1) begin
      @(negedge clk);
      if (o_ready) break;
      waited++;
      if (waited > 300) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_starved();
    int waited = 0;
    while (1) begin
      @(negedge clk);
      if (o_state == 2'b10 && !o_valid) break;
      waited++;
      if (waited > 500) begin
        check("starve_timeout", 0, 1);
        break;
      end
    end
    tick(1);
  endtask

  task automatic impulse_run();
    tbl_en = 1'b1;
    send(65536); send(0); send(0); send(0);
    wait_starved();
    check("imp_count", n_out, 16);
    tbl_en = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] rv;
    i_rst = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_data = '0; i_clear_status = 1'b0;
    build_h();
    tick(3);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_state", o_state, 0);
    check("rst_busy", o_busy, 0);
    check("rst_underrun", o_underrun, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_data", longint'(o_data), 0);
    i_rst = 1'b0;
    flush_model();
    #1;
    check("ready_after_rst", o_ready, 1);

    // Impulse with starvation after three samples, then resume.
    tbl_en = 1'b1;
    send(65536); send(0); send(0);
    wait_starved();
    check("starve_state", o_state, 2);
    check("starve_underrun", o_underrun, 1);
    check("starve_valid", o_valid, 0);
    check("starve_busy", o_busy, 0);
    check("starve_count", n_out, 12);
    send(0);
    tick(1);
    check("resume_state", o_state, 1);
    check("resume_busy", o_busy, 1);
    send(0); send(0);
    wait_starved();
    check("resume_count", n_out, 24);
    tbl_en = 1'b0;
    i_clear_status = 1'b1;
    tick(1);
    i_clear_status = 1'b0;
    check("clear_underrun", o_underrun, 0);

    // Impulse under alternating downstream ready.
    do_flush(1'b1);
    rdy_mode = 1;
    impulse_run();
    rdy_mode = 0;

    // DC gain.
    do_flush(1'b0);
    repeat (8) send(65536);
    wait_starved();
    check("dc_steady", last_out, 256);
    check("dc_overflow", o_overflow, 0);

    // Full-scale DC.
    do_flush(1'b0);
    repeat (6) send(longint'(24'h7FFFFF));
    wait_starved();
    check("fs_value", last_out, 32767);
`ifdef SSEMI_CIC_INTERP_ROUND_EN
    check("fs_overflow", o_overflow, 1);
`else
    check("fs_overflow", o_overflow, 0);
`endif
    i_clear_status = 1'b1;
    tick(1);
    i_clear_status = 1'b0;
    exp_ovf = 1'b0;
    check("fs_clear", o_overflow, 0);

    // Random data, random gaps, random downstream ready.
    do_flush(1'b0);
    rdy_mode = 2;
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 7))
        0:       rv = 24'h7FFFFF;
        1:       rv = 24'h800000;
        default: rv = IW'($urandom);
      endcase
      send(longint'($signed(rv)));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 8));
    end
    wait_starved();
    check("rand_overflow", o_overflow, exp_ovf);
    rdy_mode = 0;

    // Reset in the middle of a stream.
    do_flush(1'b0);
    for (int s = 0; s < 5; s++) begin
      rv = IW'($urandom);
      send(longint'($signed(rv)));
    end
    tick(2);
    i_rst = 1'b1;
    tick(1);
    check("mrst_valid", o_valid, 0);
    check("mrst_ready", o_ready, 0);
    check("mrst_state", o_state, 0);
    check("mrst_underrun", o_underrun, 0);
    check("mrst_overflow", o_overflow, 0);
    exp_ovf = 1'b0;
    i_rst = 1'b0;
    flush_model();
    impulse_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
